spi_slave_sync: RTL and testbench

System-clock-domain SPI slave. It is the counterpart of spi_master and sits on the far end of the ss/sck/dout/din wires.
- Unlike the sck-clocked spi_slave, every SPI input is oversampled on clk through synchronizers.
- Byte assembly and transmit shifting run as a clk-synchronous FSM, so rdata/done feed on-chip logic with no CDC.
- Mode 0 only (sck idles low; sample on rising edge, drive on falling edge). MSB/LSB order selectable.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave_sync.sv | 172 +++++++++++++++++
 tb/tb_spi_slave_sync.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the clk-domain SPI slave
package spi_pkg;
    localparam int DW_DEF = 8;
    localparam logic MLB_MSB = 1'b1;
    localparam logic MLB_LSB = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop input synchronizer with rise/fall detection
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - mode-0 SPI slave with all pins oversampled on the system clock
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          ten,
    input  logic [DW-1:0] tdata,
    input  logic          mlb,
    input  logic          ss,
    input  logic          sck,
    input  logic          sdin,
    output logic          sdout,
    output logic          sdout_oe,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic ss_rise, ss_fall, ss_lvl_unused;
    logic sck_rise, sck_fall, sck_lvl_unused;
    logic sdin_s, sdin_rise_unused, sdin_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rstb(rstb), .din(ss),
        .level(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk(clk), .rstb(rstb), .din(sck),
        .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdin_sync (
        .clk(clk), .rstb(rstb), .din(sdin),
        .level(sdin_s), .rise(sdin_rise_unused), .fall(sdin_fall_unused)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] shreg_tx_q, shreg_tx_d;
    logic [DW-1:0] shreg_rx_q, shreg_rx_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          sdout_q, sdout_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          ten_lat_q, ten_lat_d;
    logic          reload_q, reload_d;

    logic [DW-1:0] tx_shift, rx_shift;
    logic          tdata_first, tx_next_bit;

    always_comb begin
        tx_shift    = (mlb == MLB_MSB) ? {shreg_tx_q[DW-2:0], 1'b0} : {1'b0, shreg_tx_q[DW-1:1]};
        rx_shift    = (mlb == MLB_MSB) ? {shreg_rx_q[DW-2:0], sdin_s} : {sdin_s, shreg_rx_q[DW-1:1]};
        tdata_first = (mlb == MLB_MSB) ? tdata[DW-1] : tdata[0];
        tx_next_bit = (mlb == MLB_MSB) ? tx_shift[DW-1] : tx_shift[0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_tx_d = shreg_tx_q;
        shreg_rx_d = shreg_rx_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sdout_d    = sdout_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        ten_lat_d  = ten_lat_q;
        reload_d   = reload_q;

        case (state_q)
            IDLE: begin
                if (ss_fall) state_d = LOAD;
            end
            LOAD: begin
                shreg_tx_d = tdata;
                cnt_d      = '0;
                busy_d     = 1'b1;
                ten_lat_d  = ten;
                oe_d       = ten;
                sdout_d    = ten & tdata_first;
                reload_d   = 1'b0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (sck_rise) begin
                    shreg_rx_d = rx_shift;
                    if (cnt_q == CW'(DW-1)) begin
                        cnt_d    = '0;
                        rdata_d  = rx_shift;
                        done_d   = 1'b1;
                        reload_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    if (cnt_q != '0) begin
                        shreg_tx_d = tx_shift;
                        sdout_d    = ten_lat_q & tx_next_bit;
                    end else if (reload_q) begin
                        // back-to-back word: the falling edge after the last bit presents the new first bit
                        shreg_tx_d = tdata;
                        ten_lat_d  = ten;
                        oe_d       = ten;
                        sdout_d    = ten & tdata_first;
                        reload_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // ss release overrides any sck activity sampled in the same clock
        if (ss_rise) begin
            state_d    = IDLE;
            err_d      = (cnt_q != '0);
            cnt_d      = '0;
            shreg_rx_d = shreg_rx_q;
            rdata_d    = rdata_q;
            done_d     = 1'b0;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            sdout_d    = 1'b0;
            reload_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_tx_q <= '0;
            shreg_rx_q <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sdout_q    <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            ten_lat_q  <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_tx_q <= shreg_tx_d;
            shreg_rx_q <= shreg_rx_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sdout_q    <= sdout_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            ten_lat_q  <= ten_lat_d;
            reload_q   <= reload_d;
        end
    end

    assign sdout    = sdout_q;
    assign sdout_oe = oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rdata    = rdata_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - directed self-checking bench for spi_slave_sync
module tb_spi_slave_sync;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rstb, ten, mlb, ss, sck, sdin;
    logic [7:0] tdata;
    logic       sdout, sdout_oe, busy, done, err;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0, err_cnt = 0, oe_cnt = 0, hi_cnt = 0;
    int d0, e0, o0, h0;
    logic [7:0] sw, sw1, sw2;

    spi_slave_sync #(.DW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstb(rstb), .ten(ten), .tdata(tdata), .mlb(mlb),
        .ss(ss), .sck(sck), .sdin(sdin), .sdout(sdout), .sdout_oe(sdout_oe),
        .busy(busy), .done(done), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)     done_cnt++;
        if (err)      err_cnt++;
        if (sdout_oe) oe_cnt++;
        if (sdout)    hi_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // master side: present bit, sample slave on sck rise, optionally swap tdata after last rise
    task automatic send_bits(input logic [7:0] mw, input logic msb, input int nbits,
                             input logic [7:0] next_td, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx  = msb ? 7 - i : i;
            sdin = mw[idx];
            tick(H);
            sck     = 1'b1;
            rx[idx] = sdout;
            if (i == 7) tdata = next_td;
            tick(H);
            sck = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_sdout"}, {31'd0, sdout}, 32'd0);
        check({pfx, "_oe"},    {31'd0, sdout_oe}, 32'd0);
        check({pfx, "_busy"},  {31'd0, busy}, 32'd0);
        check({pfx, "_done"},  {31'd0, done}, 32'd0);
        check({pfx, "_err"},   {31'd0, err}, 32'd0);
        check({pfx, "_rdata"}, {24'd0, rdata}, 32'd0);
    endtask

    initial begin
        rstb = 1'b1; ss = 1'b1; sck = 1'b0; sdin = 1'b0;
        ten = 1'b0; mlb = 1'b1; tdata = 8'h00;
        tick(3);
        rstb = 1'b0;
        tick(1);
        check_reset_outputs("rst");

        // MSB first, 7C in / AA out
        mlb = 1'b1; ten = 1'b1; tdata = 8'hAA;
        d0 = done_cnt; e0 = err_cnt;
        ss = 1'b0; tick(6);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_oe", {31'd0, sdout_oe}, 32'd1);
        send_bits(8'h7C, 1'b1, 8, 8'hAA, sw);
        tick(H);
        check("t1_rdata", {24'd0, rdata}, 32'h7C);
        check("t1_tx", {24'd0, sw}, 32'hAA);
        check("t1_done", done_cnt - d0, 32'd1);
        ss = 1'b1; tick(6);
        check("t1_err", err_cnt - e0, 32'd0);
        check("t1_busy_off", {31'd0, busy}, 32'd0);
        check("t1_oe_off", {31'd0, sdout_oe}, 32'd0);

        // LSB first, 1C in / 55 out
        mlb = 1'b0; ten = 1'b1; tdata = 8'h55;
        d0 = done_cnt; e0 = err_cnt;
        ss = 1'b0; tick(6);
        send_bits(8'h1C, 1'b0, 8, 8'h55, sw);
        tick(H);
        check("t2_rdata", {24'd0, rdata}, 32'h1C);
        check("t2_tx", {24'd0, sw}, 32'h55);
        check("t2_done", done_cnt - d0, 32'd1);
        ss = 1'b1; tick(6);
        check("t2_err", err_cnt - e0, 32'd0);

        // back-to-back words under one ss, tdata swapped to 0F between them
        mlb = 1'b1; ten = 1'b1; tdata = 8'h3C;
        d0 = done_cnt; e0 = err_cnt;
        ss = 1'b0; tick(6);
        send_bits(8'h1C, 1'b1, 8, 8'h0F, sw1);
        tick(2);
        check("t3_rdata1", {24'd0, rdata}, 32'h1C);
        check("t3_tx1", {24'd0, sw1}, 32'h3C);
        check("t3_done1", done_cnt - d0, 32'd1);
        send_bits(8'hE3, 1'b1, 8, 8'h0F, sw2);
        tick(H);
        check("t3_rdata2", {24'd0, rdata}, 32'hE3);
        check("t3_tx2", {24'd0, sw2}, 32'h0F);
        check("t3_done2", done_cnt - d0, 32'd2);
        ss = 1'b1; tick(6);
        check("t3_err", err_cnt - e0, 32'd0);

        // abort after 5 bits
        mlb = 1'b1; ten = 1'b1; tdata = 8'hAA;
        d0 = done_cnt; e0 = err_cnt;
        ss = 1'b0; tick(6);
        send_bits(8'h55, 1'b1, 5, 8'hAA, sw);
        tick(H);
        ss = 1'b1; tick(4);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_oe", {31'd0, sdout_oe}, 32'd0);
        tick(2);
        check("t4_err", err_cnt - e0, 32'd1);
        check("t4_done", done_cnt - d0, 32'd0);
        check("t4_rdata", {24'd0, rdata}, 32'hE3);

        // receive-only transfer
        mlb = 1'b1; ten = 1'b0; tdata = 8'hFF;
        d0 = done_cnt; e0 = err_cnt; o0 = oe_cnt; h0 = hi_cnt;
        ss = 1'b0; tick(6);
        send_bits(8'hC3, 1'b1, 8, 8'hFF, sw);
        tick(H);
        check("t5_rdata", {24'd0, rdata}, 32'hC3);
        check("t5_done", done_cnt - d0, 32'd1);
        check("t5_oe_seen", oe_cnt - o0, 32'd0);
        check("t5_sdout_seen", hi_cnt - h0, 32'd0);
        check("t5_tx", {24'd0, sw}, 32'h00);
        ss = 1'b1; tick(6);
        check("t5_err", err_cnt - e0, 32'd0);

        // reset after 3 bits, then a clean transfer
        mlb = 1'b1; ten = 1'b1; tdata = 8'hAA;
        ss = 1'b0; tick(6);
        send_bits(8'h5A, 1'b1, 3, 8'hAA, sw);
        tick(2);
        d0 = done_cnt; e0 = err_cnt;
        rstb = 1'b1; ss = 1'b1; sck = 1'b0;
        tick(1);
        rstb = 1'b0;
        check_reset_outputs("t6");
        tick(6);
        check("t6_no_done", done_cnt - d0, 32'd0);
        check("t6_no_err", err_cnt - e0, 32'd0);
        ss = 1'b0; tick(6);
        send_bits(8'h96, 1'b1, 8, 8'hAA, sw);
        tick(H);
        check("t6_rdata", {24'd0, rdata}, 32'h96);
        check("t6_tx", {24'd0, sw}, 32'hAA);
        check("t6_done", done_cnt - d0, 32'd1);
        ss = 1'b1; tick(6);
        check("t6_err", err_cnt - e0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
